sbox_layer_seq: RTL

SBOX_LAYER_SEQ -- requirements
Module: sbox_layer_seq

---
 rtl/sbox_layer_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sbox_layer_seq.sv
// Nibble-serial SWAN S-box layer shared by two requesters (round datapath, key schedule).
// One S-box substitutes one nibble per cycle, MSB nibble first; results are held until consumed.
module sbox_layer_seq #(
    parameter int BLOCK_SIZE = 64,
    parameter int SBOX_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [0:BLOCK_SIZE-1] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [0:BLOCK_SIZE-1] req1_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [0:BLOCK_SIZE-1] rsp_data,
    output logic                  rsp_id,
    output logic                  busy
);

    localparam int NIB_NUM = BLOCK_SIZE / SBOX_SIZE;
    localparam int CNT_W   = (NIB_NUM > 1) ? $clog2(NIB_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [0:BLOCK_SIZE-1] data_reg, data_next;
    logic                  rsp_id_reg, rsp_id_next;
    logic                  last_reg, last_next;

    logic                  grant;
    logic [SBOX_SIZE-1:0]  nib [NIB_NUM];
    logic [SBOX_SIZE-1:0]  sbox_in;
    logic [SBOX_SIZE-1:0]  sbox_out;
    logic [0:BLOCK_SIZE-1] sub_data;

    // Split the state into nibbles and build the word with nibble cnt replaced.
    generate
        for (genvar gi = 0; gi < NIB_NUM; gi++) begin : g_nib
            assign nib[gi] = data_reg[gi*SBOX_SIZE +: SBOX_SIZE];
            assign sub_data[gi*SBOX_SIZE +: SBOX_SIZE] =
                (cnt_reg == CNT_W'(gi)) ? sbox_out : nib[gi];
        end
    endgenerate

    assign sbox_in = nib[cnt_reg];

    // The single shared SWAN S-box.
    always_comb begin
        case (sbox_in)
            4'h0: sbox_out = 4'h1;
            4'h1: sbox_out = 4'h2;
            4'h2: sbox_out = 4'hC;
            4'h3: sbox_out = 4'h5;
            4'h4: sbox_out = 4'h7;
            4'h5: sbox_out = 4'h8;
            4'h6: sbox_out = 4'hA;
            4'h7: sbox_out = 4'hF;
            4'h8: sbox_out = 4'h4;
            4'h9: sbox_out = 4'hD;
            4'hA: sbox_out = 4'hB;
            4'hB: sbox_out = 4'hE;
            4'hC: sbox_out = 4'h9;
            4'hD: sbox_out = 4'h6;
            4'hE: sbox_out = 4'h0;
            default: sbox_out = 4'h3;
        endcase
    end

    // Round-robin: on a tie the requester not served last wins; otherwise whoever is valid.
    assign grant = (req0_valid && req1_valid) ? ~last_reg : req1_valid;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        data_next   = data_reg;
        rsp_id_next = rsp_id_reg;
        last_next   = last_reg;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Gated by rst_n so the ready outputs stay low while reset is held.
                req0_ready = rst_n && req0_valid && !grant;
                req1_ready = rst_n && req1_valid && grant;
                if (req0_ready || req1_ready) begin
                    data_next   = grant ? req1_data : req0_data;
                    rsp_id_next = grant;
                    last_next   = grant;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                data_next = sub_data;
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            data_reg   <= '0;
            rsp_id_reg <= 1'b0;
            last_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            data_reg   <= data_next;
            rsp_id_reg <= rsp_id_next;
            last_reg   <= last_next;
        end
    end

    assign rsp_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign rsp_data  = data_reg;
    assign rsp_id    = rsp_id_reg;

endmodule
